// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry controller: the FSM state
// encoding, keypad geometry, one-hot helpers and the row/column to hex key map.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_t;

  // True when exactly one bit of a 4-bit line group is set.
  function automatic logic is_onehot4(input logic [3:0] oh);
    return (oh != 4'b0000) && ((oh & (oh - 4'd1)) == 4'b0000);
  endfunction

  // Index of the set bit of a one-hot 4-bit group; 0 for anything else.
  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Hex code printed on the key at (row, col) of the 4x4 pad:
  //   r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D
  function automatic logic [3:0] key_map(input logic [3:0] row_oh, input logic [3:0] col_oh);
    logic [3:0] pos;
    logic [3:0] code;
    pos = {oh_to_idx(row_oh), oh_to_idx(col_oh)};
    case (pos)
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_debounce_timer.sv
// Saturating stability counter shared by press and release debouncing.
// done_o flags that the counter sits at DEBOUNCE_CYCLES-1; it never goes past it.
module debounce_timer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up while enabled and not yet at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: turns raw row/column activity from the column
// scanner into debounced single key events and keeps a two-digit history.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] row_d_i,
  input  logic [3:0] col_dec_i,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic       key_held_o,
  output logic [3:0] digit_new_o,
  output logic [3:0] digit_old_o
);

  kp_state_t  state_q;
  kp_state_t  state_d;
  logic [3:0] cand_row_q;
  logic [3:0] cand_row_d;
  logic [3:0] cand_col_q;
  logic [3:0] cand_col_d;
  logic       key_valid_q;
  logic       key_valid_d;
  logic [3:0] key_code_q;
  logic [3:0] key_code_d;
  logic       key_held_q;
  logic       key_held_d;
  logic [3:0] digit_new_q;
  logic [3:0] digit_new_d;
  logic [3:0] digit_old_q;
  logic [3:0] digit_old_d;

  logic       sample_valid_s;
  logic       sample_match_s;
  logic       tmr_clear_s;
  logic       tmr_en_s;
  logic       tmr_done_s;
  logic       accept_s;
  logic [3:0] cand_code_s;

  assign sample_valid_s = is_onehot4(row_d_i) && is_onehot4(col_dec_i);
  assign sample_match_s = (row_d_i == cand_row_q) && (col_dec_i == cand_col_q);
  assign cand_code_s    = key_map(cand_row_q, cand_col_q);

  debounce_timer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .clear_i (tmr_clear_s),
    .enable_i(tmr_en_s),
    .done_o  (tmr_done_s)
  );

  // Next-state, candidate capture and timer control for the press/hold/release sequence.
  always_comb begin
    state_d     = state_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    accept_s    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clear_s = 1'b1;
        if (sample_valid_s) begin
          cand_row_d = row_d_i;
          cand_col_d = col_dec_i;
          state_d    = DB_PRESS;
        end else begin
          state_d    = IDLE;
        end
      end
      DB_PRESS: begin
        if (sample_match_s) begin
          if (tmr_done_s) begin
            accept_s    = 1'b1;
            tmr_clear_s = 1'b1;
            state_d     = HELD;
          end else begin
            tmr_en_s    = 1'b1;
          end
        end else begin
          // Bounce, column change or extra row: drop the candidate silently.
          tmr_clear_s = 1'b1;
          state_d     = IDLE;
        end
      end
      HELD: begin
        tmr_clear_s = 1'b1;
        if (row_d_i == 4'b0000) begin
          state_d = DB_RELEASE;
        end else begin
          // Candidate row still down, or only other keys: no rollover, keep holding.
          state_d = HELD;
        end
      end
      DB_RELEASE: begin
        if (row_d_i == 4'b0000) begin
          if (tmr_done_s) begin
            tmr_clear_s = 1'b1;
            state_d     = IDLE;
          end else begin
            tmr_en_s    = 1'b1;
          end
        end else begin
          // Any activity during release is a bounce of the held key.
          tmr_clear_s = 1'b1;
          state_d     = HELD;
        end
      end
      default: begin
        tmr_clear_s = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the digit history.
  always_comb begin
    key_valid_d = accept_s;
    key_code_d  = key_code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    key_held_d  = (state_d == HELD) || (state_d == DB_RELEASE);
    if (accept_s) begin
      key_code_d  = cand_code_s;
      digit_new_d = cand_code_s;
      digit_old_d = digit_new_q;
    end else begin
      key_code_d  = key_code_q;
      digit_new_d = digit_new_q;
      digit_old_d = digit_old_q;
    end
  end

  // State, candidate and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cand_row_q  <= 4'b0000;
      cand_col_q  <= 4'b0000;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_held_o  = key_held_q;
  assign digit_new_o = digit_new_q;
  assign digit_old_o = digit_old_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl with DEBOUNCE_CYCLES=4: directed
// scenarios plus randomized key activity against a behavioural model.
module tb_keypad_entry_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] row_d = 4'b0000;
  logic [3:0] col_dec = 4'b0000;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_pulses = 0;

  // Model: mode 0 = free, 1 = key being qualified, 2 = key accepted/held.
  int         m_mode = 0;
  int         m_run = 0;
  int         m_zero = 0;
  logic [3:0] m_row = 4'b0000;
  logic [3:0] m_col = 4'b0000;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;
  logic [3:0] m_code = 4'h0;
  logic [3:0] m_new = 4'h0;
  logic [3:0] m_old = 4'h0;
  logic [3:0] keymap [16];

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .row_d_i    (row_d),
    .col_dec_i  (col_dec),
    .key_valid_o(key_valid),
    .key_code_o (key_code),
    .key_held_o (key_held),
    .digit_new_o(digit_new),
    .digit_old_o(digit_old)
  );

  always #5 clk = ~clk;

  function automatic int bit_pos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // A key is accepted after D+1 consecutive identical valid samples and
  // released after D+1 consecutive all-zero row samples.
  task automatic model_update(input logic [3:0] r, input logic [3:0] c, input logic rn);
    logic [3:0] code;
    m_valid = 1'b0;
    if (!rn) begin
      m_mode = 0; m_run = 0; m_zero = 0; m_row = 4'b0000; m_col = 4'b0000;
      m_code = 4'h0; m_new = 4'h0; m_old = 4'h0;
    end else if (m_mode == 0) begin
      if ($countones(r) == 1 && $countones(c) == 1) begin
        m_row = r; m_col = c; m_run = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (r == m_row && c == m_col) begin
        m_run++;
        if (m_run == D + 1) begin
          code = keymap[bit_pos(m_row) * 4 + bit_pos(m_col)];
          m_mode = 2; m_zero = 0; m_valid = 1'b1;
          m_code = code; m_old = m_new; m_new = code;
        end
      end else begin
        m_mode = 0;
      end
    end else begin
      if (r == 4'b0000) m_zero++;
      else m_zero = 0;
      if (m_zero == D + 1) m_mode = 0;
    end
    m_held = (m_mode == 2);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] c, input logic rn);
    @(negedge clk);
    row_d = r; col_dec = c; nrst = rn;
    @(posedge clk);
    model_update(r, c, rn);
    #1;
    if (key_valid === 1'b1) dut_pulses++;
  endtask

  task automatic test_reset();
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    n_cmp++;
    if ({key_valid, key_code, key_held, digit_new, digit_old} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required all zero",
               {key_valid, key_code, key_held, digit_new, digit_old});
    end
  endtask

  task automatic test_basic_press();
    int p0 = dut_pulses;
    for (int i = 0; i < 18; i++) begin
      if (i < 10) step(4'b0001, 4'b0010, 1'b1);
      else step(4'b0000, 4'b0010, 1'b1);
      n_cmp++;
      if (key_valid !== m_valid || key_held !== m_held) begin
        n_bad++;
        $display("FAIL basic_cycle%0d: valid/held got %b%b required %b%b", i, key_valid, key_held, m_valid, m_held);
      end
      if (i == 4) begin
        n_cmp++;
        if (key_valid !== 1'b1 || key_code !== 4'h2 || digit_new !== 4'h2 || key_held !== 1'b1) begin
          n_bad++;
          $display("FAIL basic_accept: valid=%b code=%h new=%h held=%b required 1 2 2 1", key_valid, key_code, digit_new, key_held);
        end
      end
      if (i == 14) begin
        n_cmp++;
        if (key_held !== 1'b0 || key_code !== 4'h2) begin
          n_bad++;
          $display("FAIL basic_release: held=%b code=%h required 0 2", key_held, key_code);
        end
      end
    end
    n_cmp++;
    if (dut_pulses - p0 != 1) begin
      n_bad++;
      $display("FAIL basic_pulses: got %0d required 1", dut_pulses - p0);
    end
  endtask

  task automatic test_glitch_press();
    logic [3:0] rows [20] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000};
    int p0 = dut_pulses;
    for (int i = 0; i < 20; i++) begin
      step(rows[i], 4'b0010, 1'b1);
      n_cmp++;
      if (key_valid !== m_valid || key_held !== m_held) begin
        n_bad++;
        $display("FAIL glitch_cycle%0d: valid/held got %b%b required %b%b", i, key_valid, key_held, m_valid, m_held);
      end
    end
    n_cmp++;
    if (dut_pulses - p0 != 1 || digit_new !== 4'h5 || digit_old !== 4'h2) begin
      n_bad++;
      $display("FAIL glitch_result: pulses=%0d new=%h old=%h required 1 5 2", dut_pulses - p0, digit_new, digit_old);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = dut_pulses;
    for (int i = 0; i < 28; i++) begin
      if (i < 7) step(4'b0001, 4'b0001, 1'b1);
      else if (i < 14) step(4'b0000, 4'b0001, 1'b1);
      else if (i < 21) step(4'b0100, 4'b0100, 1'b1);
      else step(4'b0000, 4'b0100, 1'b1);
      n_cmp++;
      if (key_valid !== m_valid || key_code !== m_code) begin
        n_bad++;
        $display("FAIL b2b_cycle%0d: valid/code got %b/%h required %b/%h", i, key_valid, key_code, m_valid, m_code);
      end
    end
    n_cmp++;
    if (dut_pulses - p0 != 2 || digit_old !== 4'h1 || digit_new !== 4'h9) begin
      n_bad++;
      $display("FAIL b2b_result: pulses=%0d old=%h new=%h required 2 1 9", dut_pulses - p0, digit_old, digit_new);
    end
  endtask

  task automatic test_held_extra_and_bounce();
    logic [3:0] rows [20] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001,
                              4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000};
    int p0 = dut_pulses;
    for (int i = 0; i < 20; i++) begin
      step(rows[i], 4'b1000, 1'b1);
      n_cmp++;
      if (key_valid !== m_valid || key_held !== m_held) begin
        n_bad++;
        $display("FAIL held_cycle%0d: valid/held got %b%b required %b%b", i, key_valid, key_held, m_valid, m_held);
      end
      if (i == 16) begin
        n_cmp++;
        if (key_held !== 1'b1) begin
          n_bad++;
          $display("FAIL held_bounce: held=%b required 1", key_held);
        end
      end
    end
    n_cmp++;
    if (dut_pulses - p0 != 1 || key_code !== 4'hA || key_held !== 1'b0) begin
      n_bad++;
      $display("FAIL held_result: pulses=%0d code=%h held=%b required 1 A 0", dut_pulses - p0, key_code, key_held);
    end
  endtask

  task automatic test_invalid();
    int p0 = dut_pulses;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) step(4'b0011, 4'b0010, 1'b1);
      else step(4'b0001, 4'b0000, 1'b1);
      n_cmp++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
        n_bad++;
        $display("FAIL invalid_cycle%0d: valid/held got %b%b required 00", i, key_valid, key_held);
      end
    end
    n_cmp++;
    if (dut_pulses - p0 != 0) begin
      n_bad++;
      $display("FAIL invalid_pulses: got %0d required 0", dut_pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0 = dut_pulses;
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0001, 1'b1);
    step(4'b1000, 4'b0001, 1'b1);
    step(4'b1000, 4'b0001, 1'b0);
    n_cmp++;
    if ({key_valid, key_code, key_held, digit_new, digit_old} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_dbpress: got %b required all zero", {key_valid, key_code, key_held, digit_new, digit_old});
    end
    for (int i = 0; i < 8; i++) step(4'b1000, 4'b0001, 1'b1);
    n_cmp++;
    if (key_held !== 1'b1 || key_code !== 4'hE || dut_pulses - p0 != 1) begin
      n_bad++;
      $display("FAIL reset_repress: held=%b code=%h pulses=%0d required 1 E 1", key_held, key_code, dut_pulses - p0);
    end
    step(4'b1000, 4'b0001, 1'b0);
    n_cmp++;
    if ({key_valid, key_code, key_held, digit_new, digit_old} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_held: got %b required all zero", {key_valid, key_code, key_held, digit_new, digit_old});
    end
    step(4'b0000, 4'b0001, 1'b1);
    n_cmp++;
    if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held_after: held=%b valid=%b required 0 0", key_held, key_valid);
    end
    for (int i = 0; i < 6; i++) step(4'b0000, 4'b0001, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] c;
    int len;
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 4) == 0) begin
        r = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15));
      end else begin
        r = 4'b0001 << $urandom_range(0, 3);
        c = 4'b0001 << $urandom_range(0, 3);
      end
      if ($urandom_range(0, 2) == 0) r = 4'b0000;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        step(r, c, ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
        n_cmp++;
        if (key_valid !== m_valid || key_code !== m_code || key_held !== m_held ||
            digit_new !== m_new || digit_old !== m_old) begin
          n_bad++;
          $display("FAIL random_seg%0d: valid code held new old got %b %h %b %h %h required %b %h %b %h %h",
                   seg, key_valid, key_code, key_held, digit_new, digit_old,
                   m_valid, m_code, m_held, m_new, m_old);
        end
      end
    end
  endtask

  initial begin
    keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    test_reset();
    test_basic_press();
    test_glitch_press();
    test_back_to_back();
    test_held_extra_and_bounce();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
